// File: rtl/demorgan_vector_checker.sv
// Drives the four A/B truth-table vectors into a demorgan gate, then checks its OR/NOR outputs.
// Define DEMORGAN_CHK_FIRSTFAIL_EN to add capture of the first failing vector.
module demorgan_vector_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int SETTLE_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       a_or_b,
    input  logic       n_a_or_b,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx
`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
    ,
    output logic       first_fail_valid,
    output logic [1:0] first_fail_idx,
    output logic [1:0] first_fail_obs
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SettleLast = SETTLE_W'(1);

    state_t              state;
    state_t              stateNext;
    logic [SETTLE_W-1:0] settleCnt;
    logic [SETTLE_W-1:0] settleCntNext;
    logic                aNext;
    logic                bNext;
    logic                busyNext;
    logic                doneNext;
    logic                passNext;
    logic [2:0]          errNext;
    logic [3:0]          maskNext;
    logic [1:0]          vecNext;

    logic expOr;
    logic expNor;
    logic mismatch;

`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
    logic       ffValidNext;
    logic [1:0] ffIdxNext;
    logic [1:0] ffObsNext;
`endif

    assign expOr  = a | b;
    assign expNor = ~(a | b);

    // Four-state compare in simulation so an X/Z from the gate counts as a failure.
`ifdef SYNTHESIS
    assign mismatch = (a_or_b != expOr) || (n_a_or_b != expNor);
`else
    assign mismatch = (a_or_b !== expOr) || (n_a_or_b !== expNor);
`endif

    always_comb begin
        stateNext     = state;
        settleCntNext = settleCnt;
        aNext         = a;
        bNext         = b;
        busyNext      = busy;
        doneNext      = done;
        passNext      = pass;
        errNext       = err_count;
        maskNext      = fail_mask;
        vecNext       = vec_idx;
`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
        ffValidNext   = first_fail_valid;
        ffIdxNext     = first_fail_idx;
        ffObsNext     = first_fail_obs;
`endif
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext = DRIVE;
                    vecNext   = 2'd0;
                    aNext     = 1'b0;
                    bNext     = 1'b0;
                    errNext   = 3'd0;
                    maskNext  = 4'd0;
                    busyNext  = 1'b1;
                    doneNext  = 1'b0;
                    passNext  = 1'b0;
`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
                    ffValidNext = 1'b0;
                    ffIdxNext   = 2'd0;
                    ffObsNext   = 2'd0;
`endif
                end
            end
            DRIVE: begin
                settleCntNext = SettleLoad;
                stateNext     = SETTLE;
            end
            SETTLE: begin
                settleCntNext = settleCnt - SettleLast;
                // <= guards against a zero load hanging the run
                if (settleCnt <= SettleLast) begin
                    stateNext = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    maskNext[vec_idx] = 1'b1;
                    errNext           = err_count + 3'd1;
`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
                    if (!first_fail_valid) begin
                        ffValidNext = 1'b1;
                        ffIdxNext   = vec_idx;
                        ffObsNext   = {a_or_b, n_a_or_b};
                    end
`endif
                end
                if (vec_idx == 2'd3) begin
                    stateNext = DONE;
                    busyNext  = 1'b0;
                    doneNext  = 1'b1;
                    passNext  = (errNext == 3'd0);
                end else begin
                    stateNext      = DRIVE;
                    vecNext        = vec_idx + 2'd1;
                    {aNext, bNext} = vec_idx + 2'd1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            settleCnt <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
            vec_idx   <= 2'd0;
        end else begin
            state     <= stateNext;
            settleCnt <= settleCntNext;
            a         <= aNext;
            b         <= bNext;
            busy      <= busyNext;
            done      <= doneNext;
            pass      <= passNext;
            err_count <= errNext;
            fail_mask <= maskNext;
            vec_idx   <= vecNext;
        end
    end

`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 2'd0;
            first_fail_obs   <= 2'd0;
        end else begin
            first_fail_valid <= ffValidNext;
            first_fail_idx   <= ffIdxNext;
            first_fail_obs   <= ffObsNext;
        end
    end
`endif

endmodule

// File: tb/tb_demorgan_vector_checker.sv
// Bench for demorgan_vector_checker: table of gate fault modes plus reset,
// held-start and long-settle sequences, checked cycle by cycle.
module tb_demorgan_vector_checker;

    typedef struct {
        logic [2:0] mode;
        logic [2:0] err;
        logic [3:0] mask;
        logic       pass;
        logic       ffValid;
        logic [1:0] ffIdx;
        logic [1:0] ffObs;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start3 = 1'b0;
    logic [2:0] mode = 3'd0;

    logic a1, b1, busy1, done1, pass1, orOut1, norOut1;
    logic [2:0] err1;
    logic [3:0] mask1;
    logic [1:0] vec1;
    logic a3, b3, busy3, done3, pass3, orOut3, norOut3;
    logic [2:0] err3;
    logic [3:0] mask3;
    logic [1:0] vec3;
`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
    logic       ffValid1, ffValid3;
    logic [1:0] ffIdx1, ffObs1, ffIdx3, ffObs3;
`endif

    int total = 0;
    int passed = 0;
    vec_t tbl[5];
    vec_t sbq[$];

    always #5 clk = ~clk;

    // Gate model with selectable faults
    always_comb begin
        orOut1  = a1 | b1;
        norOut1 = ~(a1 | b1);
        case (mode)
            3'd1: orOut1 = 1'b0;
            3'd2: norOut1 = a1 | b1;
            3'd3: norOut1 = 1'b1;
            3'd4: begin
                orOut1  = ~(a1 | b1);
                norOut1 = a1 | b1;
            end
            default: ;
        endcase
    end

    assign orOut3  = a3 | b3;
    assign norOut3 = ~(a3 | b3);

    demorgan_vector_checker #(.SETTLE_CYCLES(1), .SETTLE_W(4)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .a_or_b(orOut1), .n_a_or_b(norOut1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1), .vec_idx(vec1)
`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
        , .first_fail_valid(ffValid1), .first_fail_idx(ffIdx1),
        .first_fail_obs(ffObs1)
`endif
    );

    demorgan_vector_checker #(.SETTLE_CYCLES(3), .SETTLE_W(4)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .a_or_b(orOut3), .n_a_or_b(norOut3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_mask(mask3), .vec_idx(vec3)
`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
        , .first_fail_valid(ffValid3), .first_fail_idx(ffIdx3),
        .first_fail_obs(ffObs3)
`endif
    );

    function automatic void chk(string name, logic [15:0] act,
                                logic [15:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        else
            passed++;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks one run on dut1 from the start edge; start left as given.
    task automatic traceRun1(input string tag);
        logic [1:0] v;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            v = 2'(k / 3);
            chk({tag, "_seq"}, 16'({busy1, done1, vec1, a1, b1}),
                16'({1'b1, 1'b0, v, v}));
        end
        tick();
        chk({tag, "_done"}, 16'({busy1, done1}), 16'b01);
    endtask

    task automatic popCheck(input string tag);
        vec_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sbq_empty"}, 16'd1, 16'd0);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_err"}, 16'(err1), 16'(e.err));
        chk({tag, "_mask"}, 16'(mask1), 16'(e.mask));
        chk({tag, "_pass"}, 16'(pass1), 16'(e.pass));
`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
        chk({tag, "_ffv"}, 16'(ffValid1), 16'(e.ffValid));
        if (e.ffValid)
            chk({tag, "_ff"}, 16'({ffIdx1, ffObs1}),
                16'({e.ffIdx, e.ffObs}));
`endif
    endtask

    task automatic runVec(input vec_t r, input string tag);
        mode = r.mode;
        sbq.push_back(r);
        start = 1'b1;
        tick();
        start = 1'b0;
        traceRun1(tag);
        popCheck(tag);
        tick();
        chk({tag, "_hold"}, 16'({done1, err1, mask1}),
            16'({1'b1, r.err, r.mask}));
    endtask

    initial begin
        tbl[0] = '{3'd0, 3'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00};
        tbl[1] = '{3'd1, 3'd3, 4'b1110, 1'b0, 1'b1, 2'd1, 2'b00};
        tbl[2] = '{3'd2, 3'd4, 4'b1111, 1'b0, 1'b1, 2'd0, 2'b00};
        tbl[3] = '{3'd3, 3'd3, 4'b1110, 1'b0, 1'b1, 2'd1, 2'b11};
        tbl[4] = '{3'd4, 3'd4, 4'b1111, 1'b0, 1'b1, 2'd0, 2'b10};

        tick();
        tick();
        chk("reset1", 16'({a1, b1, busy1, done1, pass1, err1, mask1, vec1}),
            16'd0);
        chk("reset3", 16'({a3, b3, busy3, done3, pass3, err3, mask3, vec3}),
            16'd0);
        reset = 1'b0;
        tick();
        chk("idle", 16'({busy1, done1}), 16'd0);

        for (int i = 0; i < 5; i++)
            runVec(tbl[i], $sformatf("tbl%0d", i));

        // Reset mid-run after vector 0 has already failed
        mode  = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        chk("midrun_partial", 16'(err1), 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrun_reset",
            16'({a1, b1, busy1, done1, pass1, err1, mask1, vec1}), 16'd0);
        tick();
        chk("midrun_idle", 16'({busy1, done1}), 16'd0);
        runVec(tbl[0], "postreset");

        // Start held high: ignored while busy, restarts from DONE
        mode  = 3'd0;
        start = 1'b1;
        tick();
        traceRun1("held");
        chk("held_pass", 16'({pass1, err1}), 16'h8);
        tick();
        chk("held_restart", 16'({busy1, done1, a1, b1}), 16'b1000);
        start = 1'b0;
        for (int k = 1; k < 12; k++) tick();
        chk("held_notyet", 16'(done1), 16'd0);
        tick();
        chk("held_done2", 16'({done1, pass1}), 16'b11);

        // Longer settle: each vector held five cycles
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            logic [1:0] v;
            if (k > 0) tick();
            v = 2'(k / 5);
            chk("s3_seq", 16'({busy3, done3, vec3, a3, b3}),
                16'({1'b1, 1'b0, v, v}));
        end
        tick();
        chk("s3_done", 16'({busy3, done3, pass3, err3, mask3}),
            16'({1'b0, 1'b1, 1'b1, 3'd0, 4'd0}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/demorgan_vector_checker.md
Name: demorgan_vector_checker

Overview:
- Self-checking sequential stage that wraps the demorgan gate block.
- Upstream side: generates the four A/B truth-table vectors, 00, 01, 10, 11, one at a time. Holds each vector for a programmable settle time.
- Downstream side: samples the DUT's OR and NOR outputs, compares them against expected values, and accumulates a per-vector fail mask and an error count.
- Replaces hand-read $display truth tables with a synthesizable pass/fail result for board bring-up and regression.

Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held after the drive cycle before sampling; legal range 1..15.
- SETTLE_W, 4, width of the internal settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse or level; begins a run when sampled high in IDLE or DONE.
- a_or_b  input  1  DUT output A+B.
- n_a_or_b  input  1  DUT output ~(A+B).
- a  output  1  stimulus A to DUT, registered.
- b  output  1  stimulus B to DUT, registered.
- busy  output  1  high while a run is in progress (DRIVE, SETTLE, SAMPLE).
- done  output  1  high in DONE; holds until next start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  3  number of failing vectors, 0..4.
- fail_mask  output  4  bit i set if vector i failed (i = {a,b}).
- vec_idx  output  2  index of the vector currently driven.

Behaviour:
- Reset (synchronous, active-high, dominant over all else): state=IDLE; a=b=0, busy=done=pass=0, err_count=0, fail_mask=0, vec_idx=0, settle counter=0.
- Reset asserted mid-run aborts the run immediately. No partial results are retained.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> DRIVE. Same edge: vec_idx=0, a=0, b=0, err_count=0, fail_mask=0, busy=1.
- DRIVE: one cycle; loads settle counter with SETTLE_CYCLES -> SETTLE.
- SETTLE: decrement each cycle; at count 1 -> SAMPLE. Total SETTLE_CYCLES cycles.
- SAMPLE: one cycle; compare inputs in that cycle.
  - expected_or = a|b; expected_nor = ~(a|b).
  - Mismatch if a_or_b!=expected_or OR n_a_or_b!=expected_nor.
  - On mismatch: fail_mask[vec_idx]<=1, err_count<=err_count+1. Saturation is not needed; max is 4.
  - If vec_idx==3 -> DONE: busy=0, done=1, pass=(final err_count==0). pass must include the vector-3 result in the same edge.
  - Else -> DRIVE with vec_idx+1; {a,b}=vec_idx+1 on the same edge.
- DONE: outputs held stable. start=1 -> behaves as IDLE start (clears results, done=0, DRIVE).
- start while busy is ignored.
- X/Z on DUT inputs during SAMPLE counts as a mismatch: compare with !==-equivalent semantics in sim, plain compare in synthesis.
- Latency: start sampled at edge N -> a/b valid after N. done=1 after edge N+4*(2+SETTLE_CYCLES). Default: N+12.
- a,b change only on edges entering DRIVE; stable through SETTLE and SAMPLE.

Optional Feature:
- Macro: DEMORGAN_CHK_FIRSTFAIL_EN.
- Defined: adds outputs first_fail_valid (1), first_fail_idx (2), first_fail_obs (2, {a_or_b,n_a_or_b}).
  - These capture the first mismatching vector of a run.
  - They clear on start and reset, and are held thereafter; later failures do not overwrite them.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Correct demorgan DUT, SETTLE_CYCLES=1, start at edge N -> a,b sequence 00,01,10,11 each held 3 cycles; done=1 at N+12; pass=1, err_count=0, fail_mask=0000.
- a_or_b stuck at 0, n_a_or_b correct -> vectors 1,2,3 fail; err_count=3, fail_mask=1110, pass=0. With FIRSTFAIL_EN: first_fail_idx=1, first_fail_obs=00.
- n_a_or_b tied to a_or_b (correct OR) -> all vectors fail; err_count=4, fail_mask=1111, pass=0.
- Reset asserted for one cycle at N+5 mid-run -> next cycle a=b=0, busy=0, done=0, err_count=0. A new start gives a full clean 12-cycle run.
- start held high through the run -> ignored while busy. Run completes at N+12. Restarts on the cycle after DONE is entered, since start is still high: done=0, a,b=00.
- SETTLE_CYCLES=3, correct DUT -> each vector held 5 cycles; done=1 at N+20; pass=1.
